// File: rtl/pic_pkg.sv
// Shared types and constants for the PIC INTA responder.
package pic_pkg;

  localparam int         PIC_NUM_IRQ        = 8;
  localparam logic [2:0] PIC_SPURIOUS_LEVEL = 3'd7;
  localparam int         PIC_VEC_BASE_W     = 5;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    REQ   = 3'd1,
    ACK1  = 3'd2,
    WAIT2 = 3'd3,
    ACK2  = 3'd4
  } pic_ack_state_t;

  // Index of the lowest set bit (IR0 is highest priority); 0 when v is empty.
  function automatic logic [2:0] pic_lowest_set(input logic [PIC_NUM_IRQ-1:0] v);
    logic [2:0] idx;
    idx = '0;
    for (int i = PIC_NUM_IRQ - 1; i >= 0; i--) begin
      if (v[i]) idx = 3'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/pic_prio_resolver.sv
// Fully nested priority resolver: picks the highest-priority pending IR and
// qualifies it against the highest-priority level already in service.
module pic_prio_resolver
  import pic_pkg::*;
(
  input  logic [PIC_NUM_IRQ-1:0] irr,
  input  logic [PIC_NUM_IRQ-1:0] isr,
  output logic [2:0]             winner,
  output logic                   winner_valid,
  output logic [2:0]             isr_top
);

  // Winner must strictly outrank everything in service to interrupt it.
  always_comb begin
    winner       = pic_lowest_set(irr);
    isr_top      = pic_lowest_set(isr);
    winner_valid = (irr != '0) && ((isr == '0) || (winner < isr_top));
  end

endmodule

// File: rtl/pic_inta_responder.sv
// CPU-side responder of an 8259-style PIC: INT generation, two-pulse 8086
// INTA handshake, in-service register and EOI handling.
// Optional feature macro: PIC_AUTO_EOI_EN (adds the aeoi port; auto-EOI on
// the trailing edge of the second INTA pulse).
module pic_inta_responder
  import pic_pkg::*;
#(
  parameter int INTA_SYNC_STAGES = 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [PIC_NUM_IRQ-1:0]    irr,
  input  logic [PIC_VEC_BASE_W-1:0] vector_base,
  input  logic                      eoi_valid,
  input  logic                      eoi_specific,
  input  logic [2:0]                eoi_level,
`ifdef PIC_AUTO_EOI_EN
  input  logic                      aeoi,
`endif
  input  logic                      inta_n,
  output logic                      int_out,
  output logic [PIC_NUM_IRQ-1:0]    isr,
  output logic [PIC_NUM_IRQ-1:0]    irr_clear,
  output logic [7:0]                data_out,
  output logic                      data_oe,
  output logic                      spurious
);

  pic_ack_state_t state, state_nxt;

  logic [INTA_SYNC_STAGES-1:0] inta_pipe;
  logic                        inta_prev;
  logic                        inta_s, inta_fall, inta_rise;

  logic [2:0]             winner, isr_top, lvl, lvl_nxt;
  logic                   winner_valid;
  logic                   int_nxt, data_oe_nxt, spurious_nxt;
  logic [7:0]             data_out_nxt;
  logic [PIC_NUM_IRQ-1:0] isr_set, auto_clr, eoi_clr, irr_clear_nxt, isr_nxt;

  pic_prio_resolver u_prio (
    .irr          (irr),
    .isr          (isr),
    .winner       (winner),
    .winner_valid (winner_valid),
    .isr_top      (isr_top)
  );

  // inta_n synchronizer plus one history flop for edge detection; idles high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inta_pipe <= '1;
      inta_prev <= 1'b1;
    end else begin
      inta_pipe <= {inta_pipe[INTA_SYNC_STAGES-2:0], inta_n};
      inta_prev <= inta_pipe[INTA_SYNC_STAGES-1];
    end
  end

  assign inta_s    = inta_pipe[INTA_SYNC_STAGES-1];
  assign inta_fall = inta_prev & ~inta_s;
  assign inta_rise = ~inta_prev & inta_s;

  // EOI clear mask; a non-specific EOI uses the resolver's in-service top.
  always_comb begin
    eoi_clr = '0;
    if (eoi_valid) begin
      if (eoi_specific)  eoi_clr[eoi_level] = 1'b1;
      else if (|isr)     eoi_clr[isr_top]   = 1'b1;
    end
  end

  // Next-state and registered-output values for the INTA handshake.
  always_comb begin
    state_nxt     = state;
    int_nxt       = int_out;
    lvl_nxt       = lvl;
    data_out_nxt  = data_out;
    data_oe_nxt   = data_oe;
    spurious_nxt  = 1'b0;
    irr_clear_nxt = '0;
    isr_set       = '0;
    auto_clr      = '0;
    case (state)
      IDLE: begin
        if (winner_valid) begin
          state_nxt = REQ;
          int_nxt   = 1'b1;
        end
      end
      REQ: begin
        // The INTA edge wins over a vanished request: the CPU is already
        // committed to the cycle, so it gets the spurious vector.
        if (inta_fall) begin
          state_nxt = ACK1;
          int_nxt   = 1'b0;
          if (winner_valid) begin
            lvl_nxt                = winner;
            isr_set[winner]        = 1'b1;
            irr_clear_nxt[winner]  = 1'b1;
          end else begin
            lvl_nxt      = PIC_SPURIOUS_LEVEL;
            spurious_nxt = 1'b1;
          end
        end else if (!winner_valid) begin
          state_nxt = IDLE;
          int_nxt   = 1'b0;
        end
      end
      ACK1: begin
        if (inta_rise) state_nxt = WAIT2;
      end
      WAIT2: begin
        if (inta_fall) begin
          state_nxt    = ACK2;
          data_oe_nxt  = 1'b1;
          data_out_nxt = {vector_base, lvl};
        end
      end
      ACK2: begin
        if (inta_rise) begin
          state_nxt    = IDLE;
          data_oe_nxt  = 1'b0;
          data_out_nxt = 8'h00;
`ifdef PIC_AUTO_EOI_EN
          if (aeoi) auto_clr[lvl] = 1'b1;
`endif
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
    // Clears first, then the acknowledge set, so a shared bit stays set.
    isr_nxt = (isr & ~(eoi_clr | auto_clr)) | isr_set;
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      int_out   <= 1'b0;
      isr       <= '0;
      irr_clear <= '0;
      data_out  <= 8'h00;
      data_oe   <= 1'b0;
      spurious  <= 1'b0;
      lvl       <= '0;
    end else begin
      state     <= state_nxt;
      int_out   <= int_nxt;
      isr       <= isr_nxt;
      irr_clear <= irr_clear_nxt;
      data_out  <= data_out_nxt;
      data_oe   <= data_oe_nxt;
      spurious  <= spurious_nxt;
      lvl       <= lvl_nxt;
    end
  end

endmodule

// File: tb/tb_pic_inta_responder.sv
// Self-checking bench for pic_inta_responder: directed scenarios plus a
// randomized request/EOI mix against a behavioural ISR model.
module tb_pic_inta_responder;

  localparam int S = 2;       // synchronizer depth
  localparam int H = S + 3;   // INTA phase length in clocks

  logic       clk, rst_n;
  logic [7:0] irr;
  logic [4:0] vector_base;
  logic       eoi_valid, eoi_specific;
  logic [2:0] eoi_level;
  logic       inta_n;
`ifdef PIC_AUTO_EOI_EN
  logic       aeoi;
`endif
  logic       int_out, data_oe, spurious;
  logic [7:0] isr, irr_clear, data_out;

  int n_cmp = 0;
  int n_err = 0;
  logic [7:0] isr_m;   // reference in-service register

  pic_inta_responder #(.INTA_SYNC_STAGES(S)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .irr          (irr),
    .vector_base  (vector_base),
    .eoi_valid    (eoi_valid),
    .eoi_specific (eoi_specific),
    .eoi_level    (eoi_level),
`ifdef PIC_AUTO_EOI_EN
    .aeoi         (aeoi),
`endif
    .inta_n       (inta_n),
    .int_out      (int_out),
    .isr          (isr),
    .irr_clear    (irr_clear),
    .data_out     (data_out),
    .data_oe      (data_oe),
    .spurious     (spurious)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: index of highest-priority (lowest-numbered) set bit, -1 if none.
  function automatic int top_of(input logic [7:0] v);
    for (int i = 0; i < 8; i++) if (v[i]) return i;
    return -1;
  endfunction

  // Reference: does the pending set interrupt the current in-service set?
  function automatic bit qualifies(input logic [7:0] r, input logic [7:0] s);
    if (top_of(r) < 0) return 1'b0;
    if (top_of(s) < 0) return 1'b1;
    return top_of(r) < top_of(s);
  endfunction

  // Drives a full two-pulse INTA sequence starting at a falling clock edge.
  // hook 1: drop irr in the cycle the first edge is detected.
  // hook 2: fire a specific EOI at hook_lvl in that same cycle.
  task automatic run_inta(input int hook, input logic [2:0] hook_lvl,
                          output logic [7:0] clr, output int spur,
                          output logic [7:0] vec, output int oe_on,
                          output int oe_off, output logic [7:0] isr1);
    clr = '0; spur = 0; vec = '0; oe_on = -1; oe_off = -1;
    inta_n = 1'b0;
    for (int i = 1; i <= H; i++) begin
      @(negedge clk);
      clr |= irr_clear;
      spur += int'(spurious);
      if (i == S && hook == 1) irr = '0;
      if (i == S && hook == 2) begin
        eoi_valid = 1'b1; eoi_specific = 1'b1; eoi_level = hook_lvl;
      end
      if (i == S + 1) eoi_valid = 1'b0;
    end
    isr1 = isr;
    inta_n = 1'b1;
    repeat (H) @(negedge clk);
    inta_n = 1'b0;
    for (int i = 1; i <= H; i++) begin
      @(negedge clk);
      if (data_oe && oe_on < 0) begin oe_on = i; vec = data_out; end
    end
    inta_n = 1'b1;
    for (int i = 1; i <= H; i++) begin
      @(negedge clk);
      if (!data_oe && oe_off < 0) oe_off = i;
    end
  endtask

  task automatic send_eoi(input bit specific, input logic [2:0] level);
    eoi_valid = 1'b1; eoi_specific = specific; eoi_level = level;
    @(negedge clk);
    eoi_valid = 1'b0;
    if (specific) isr_m[level] = 1'b0;
    else if (top_of(isr_m) >= 0) isr_m[top_of(isr_m)] = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; irr = '0; vector_base = 5'h08; eoi_valid = 0;
    eoi_specific = 0; eoi_level = '0; inta_n = 1'b1;
`ifdef PIC_AUTO_EOI_EN
    aeoi = 1'b0;
`endif
    isr_m = '0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({int_out, isr, irr_clear, data_out, data_oe, spurious} !== 28'h0) begin
      n_err++;
      $display("FAIL reset_outputs: got int=%b isr=%h clr=%h dout=%h oe=%b sp=%b want all 0",
               int_out, isr, irr_clear, data_out, data_oe, spurious);
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    n_cmp++;
    if (int_out !== 1'b0) begin n_err++; $display("FAIL reset_idle_int: got %b want 0", int_out); end
  endtask

  task automatic test_basic_ack();
    logic [7:0] clr, vec, isr1; int spur, on, off;
    irr = 8'h24; vector_base = 5'h08;
    @(negedge clk);
    n_cmp++;
    if (int_out !== 1'b1) begin n_err++; $display("FAIL basic_int_rise: got %b want 1", int_out); end
    run_inta(0, 3'd0, clr, spur, vec, on, off, isr1);
    isr_m = 8'h04;
    n_cmp++;
    if (isr1 !== 8'h04) begin n_err++; $display("FAIL basic_isr: got %h want 04", isr1); end
    n_cmp++;
    if (clr !== 8'h04) begin n_err++; $display("FAIL basic_irr_clear: got %h want 04", clr); end
    n_cmp++;
    if (vec !== 8'h42) begin n_err++; $display("FAIL basic_vector: got %h want 42", vec); end
    n_cmp++;
    if (on !== S + 1 || off !== S + 1) begin
      n_err++; $display("FAIL basic_oe_latency: got on=%0d off=%0d want %0d", on, off, S + 1);
    end
    n_cmp++;
    if (spur !== 0) begin n_err++; $display("FAIL basic_no_spurious: got %0d want 0", spur); end
  endtask

  task automatic test_nesting();
    logic [7:0] clr, vec, isr1; int spur, on, off;
    irr = 8'h08;
    repeat (3) @(negedge clk);
    n_cmp++;
    if (int_out !== 1'b0) begin n_err++; $display("FAIL nest_blocked: got %b want 0", int_out); end
    irr = 8'h02;
    @(negedge clk);
    n_cmp++;
    if (int_out !== 1'b1) begin n_err++; $display("FAIL nest_preempt_int: got %b want 1", int_out); end
    run_inta(0, 3'd0, clr, spur, vec, on, off, isr1);
    irr = '0;
    isr_m = 8'h06;
    n_cmp++;
    if (isr !== 8'h06) begin n_err++; $display("FAIL nest_isr: got %h want 06", isr); end
  endtask

  task automatic test_eoi();
    send_eoi(1'b0, 3'd0);
    n_cmp++;
    if (isr !== 8'h04) begin n_err++; $display("FAIL eoi_nonspecific: got %h want 04", isr); end
    send_eoi(1'b1, 3'd2);
    n_cmp++;
    if (isr !== 8'h00) begin n_err++; $display("FAIL eoi_specific: got %h want 00", isr); end
    send_eoi(1'b0, 3'd5);
    n_cmp++;
    if (isr !== 8'h00) begin n_err++; $display("FAIL eoi_empty_noop: got %h want 00", isr); end
  endtask

  task automatic test_spurious();
    logic [7:0] clr, vec, isr1; int spur, on, off;
    irr = 8'h10; vector_base = 5'h08;
    @(negedge clk);
    run_inta(1, 3'd0, clr, spur, vec, on, off, isr1);
    n_cmp++;
    if (spur !== 1) begin n_err++; $display("FAIL spur_pulse: got %0d want 1", spur); end
    n_cmp++;
    if (clr !== 8'h00) begin n_err++; $display("FAIL spur_irr_clear: got %h want 00", clr); end
    n_cmp++;
    if (vec !== 8'h47) begin n_err++; $display("FAIL spur_vector: got %h want 47", vec); end
    n_cmp++;
    if (isr1 !== isr_m) begin n_err++; $display("FAIL spur_isr: got %h want %h", isr1, isr_m); end
  endtask

  task automatic test_eoi_collision();
    logic [7:0] clr, vec, isr1; int spur, on, off;
    irr = 8'h08;
    @(negedge clk);
    run_inta(0, 3'd0, clr, spur, vec, on, off, isr1);
    irr = 8'h02;
    @(negedge clk);
    run_inta(2, 3'd1, clr, spur, vec, on, off, isr1);
    irr = '0;
    isr_m = 8'h0A;
    n_cmp++;
    if (isr1 !== 8'h0A) begin n_err++; $display("FAIL eoi_set_collision: got %h want 0a", isr1); end
    send_eoi(1'b1, 3'd1);
    send_eoi(1'b1, 3'd3);
  endtask

  task automatic test_reset_wait2();
    logic [7:0] clr, vec, isr1; int spur, on, off;
    irr = 8'h01;
    @(negedge clk);
    inta_n = 1'b0; repeat (H) @(negedge clk);
    inta_n = 1'b1; repeat (H) @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({data_oe, isr, int_out, data_out} !== 18'h0) begin
      n_err++;
      $display("FAIL rst_wait2: got oe=%b isr=%h int=%b dout=%h want 0", data_oe, isr, int_out, data_out);
    end
    irr = '0; isr_m = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    irr = 8'h04; vector_base = 5'h1F;
    @(negedge clk);
    n_cmp++;
    if (int_out !== 1'b1) begin n_err++; $display("FAIL rst_fresh_int: got %b want 1", int_out); end
    run_inta(0, 3'd0, clr, spur, vec, on, off, isr1);
    irr = '0; isr_m = 8'h04;
    n_cmp++;
    if (vec !== 8'hFA || isr !== 8'h04) begin
      n_err++; $display("FAIL rst_fresh_ack: got vec=%h isr=%h want fa/04", vec, isr);
    end
    send_eoi(1'b0, 3'd0);
  endtask

`ifdef PIC_AUTO_EOI_EN
  task automatic test_auto_eoi();
    logic [7:0] clr, vec, isr1; int spur, on, off;
    aeoi = 1'b1; irr = 8'h01;
    @(negedge clk);
    run_inta(0, 3'd0, clr, spur, vec, on, off, isr1);
    irr = '0;
    n_cmp++;
    if (isr1 !== 8'h01) begin n_err++; $display("FAIL aeoi_after_first: got %h want 01", isr1); end
    n_cmp++;
    if (isr !== 8'h00) begin n_err++; $display("FAIL aeoi_after_second: got %h want 00", isr); end
    aeoi = 1'b0;
  endtask
`endif

  task automatic test_random();
    logic [7:0] clr, vec, isr1, r; int spur, on, off, w; bit exp_int;
    for (int it = 0; it < 40; it++) begin
      if ($urandom_range(0, 2) != 0) begin
        r = 8'($urandom_range(0, 255));
        vector_base = 5'($urandom_range(0, 31));
        irr = r;
        @(negedge clk);
        exp_int = qualifies(r, isr_m);
        n_cmp++;
        if (int_out !== exp_int) begin
          n_err++; $display("FAIL rnd_int it=%0d irr=%h isr=%h: got %b want %b", it, r, isr_m, int_out, exp_int);
        end
        if (exp_int) begin
          w = top_of(r);
          run_inta(0, 3'd0, clr, spur, vec, on, off, isr1);
          isr_m[w] = 1'b1;
          n_cmp++;
          if (clr !== 8'(1 << w) || vec !== {vector_base, 3'(w)} || isr1 !== isr_m) begin
            n_err++;
            $display("FAIL rnd_ack it=%0d: got clr=%h vec=%h isr=%h want %h/%h/%h",
                     it, clr, vec, isr1, 8'(1 << w), {vector_base, 3'(w)}, isr_m);
          end
        end
        irr = '0;
        @(negedge clk);
      end else begin
        send_eoi(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)));
      end
      n_cmp++;
      if (isr !== isr_m) begin n_err++; $display("FAIL rnd_isr it=%0d: got %h want %h", it, isr, isr_m); end
    end
  endtask

  initial begin
    test_reset();
    test_basic_ack();
    test_nesting();
    test_eoi();
    test_spurious();
    test_eoi_collision();
    test_reset_wait2();
`ifdef PIC_AUTO_EOI_EN
    test_auto_eoi();
`endif
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/pic_inta_responder.md
# pic_inta_responder

CPU-side responder of the 8259-style PIC. Takes the masked pending-request vector from the interrupt request register and resolves priority in fully nested mode (IR0 highest). It drives INT to the CPU and runs the two-pulse 8086 INTA sequence: the first pulse freezes the winner and the second places the vector on the data bus. It also maintains the in-service register (ISR) and executes EOI commands from the command logic.

## Interface
- INTA_SYNC_STAGES, 2, flops in the inta_n synchronizer (minimum 2)
- clk  in  1  system clock, all state on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- irr  in  8  pending requests from the IRR block, already masked; bit n = IRn
- vector_base  in  5  T7..T3 from ICW2
- eoi_valid  in  1  one-cycle EOI command strobe
- eoi_specific  in  1  1 = specific EOI, 0 = non-specific; sampled with eoi_valid
- eoi_level  in  3  target level for a specific EOI
- inta_n  in  1  CPU acknowledge, asynchronous, active-low
- int_out  out  1  interrupt request to the CPU, registered
- isr  out  8  in-service register
- irr_clear  out  8  one-cycle one-hot pulse that clears the acknowledged IRR bit
- data_out  out  8  vector byte
- data_oe  out  1  data bus drive enable
- spurious  out  1  one-cycle pulse when the first INTA finds no valid winner

## Operation
- Winner = lowest-index set bit of irr. It qualifies only when its index is below the lowest-index set bit of isr, or when isr == 0.
- FSM states: IDLE, REQ, ACK1, WAIT2, ACK2.
- IDLE: a qualifying winner exists -> REQ, and int_out is set.
- REQ:
  - Falling edge of synchronized inta_n -> ACK1. Clear int_out and latch lvl = winner.
  - In the same cycle, set isr[lvl] and pulse irr_clear[lvl].
  - If no winner qualifies at that edge, then lvl = 7, isr is unchanged, irr_clear = 0, and spurious pulses.
  - If the qualifying request disappears before INTA, int_out drops and the FSM returns to IDLE.
- ACK1: rising edge of synchronized inta_n -> WAIT2. data_oe stays 0.
- WAIT2: falling edge -> ACK2. Set data_oe = 1 and data_out = {vector_base, lvl}.
- ACK2: rising edge -> IDLE. Clear data_oe; data_out returns to 8'h00.
- Non-specific EOI clears the lowest-index set bit of isr, evaluated on the pre-edge isr. It is a no-op if isr == 0.
- Specific EOI clears isr[eoi_level].
- EOI and ISR set in the same cycle: the clear is applied first, then the set, so a common bit ends set.
- EOI is accepted in every FSM state.
- rst_n low in any state: immediately returns to IDLE with all outputs cleared.

## Timing
- Reset values: int_out = 0, isr = 8'h00, irr_clear = 0, data_out = 8'h00, data_oe = 0, spurious = 0, state = IDLE, lvl = 0.
- int_out rises 1 clk after a qualifying irr bit is present in IDLE.
- INTA edge detection latency is INTA_SYNC_STAGES + 1 clk from the pin edge.
- data_oe is asserted that many cycles after the second falling edge. It is released the same number of cycles after the second rising edge.
- The CPU must hold each INTA low and high phase for at least INTA_SYNC_STAGES + 2 clk. Shorter pulses are unsupported and need not be detected.
- The isr update and the irr_clear pulse both occur in the cycle that enters ACK1.

## Configuration
- PIC_AUTO_EOI_EN defined:
  - Adds input port aeoi (1 bit, ICW4 AEOI).
  - When aeoi = 1, isr[lvl] is cleared in the cycle ACK2 -> IDLE.
  - When aeoi = 0, behaviour is identical to the undefined case.
- PIC_AUTO_EOI_EN undefined: the aeoi port is absent, and isr bits clear only through EOI commands.

## Structure
- Shared package pic_pkg holds:
  - the state enum pic_ack_state_t
  - PIC_NUM_IRQ = 8
  - PIC_SPURIOUS_LEVEL = 3'd7
  - PIC_VEC_BASE_W = 5
- Sub-module pic_prio_resolver: combinational; inputs irr and isr; outputs winner[2:0], winner_valid and isr_top[2:0]. It is reused for the non-specific EOI lookup.
- The synchronizer and edge detector are inline.

## Test plan
- irr = 8'h24, isr = 0, vector_base = 5'h08, two INTA pulses -> int_out rises, isr = 8'h04, irr_clear = 8'h04, data_out = 8'h42 during the second pulse.
- isr = 8'h04, irr = 8'h08 -> int_out stays 0. Then irr = 8'h02 -> int_out = 1, and after the INTA sequence isr = 8'h06.
- isr = 8'h06, non-specific EOI -> isr = 8'h04. Specific EOI with level 2 -> isr = 8'h00.
- irr drops to 0 after int_out rises but before INTA, with the FSM held in REQ by glitch timing -> spurious pulses, data_out = {vector_base, 3'd7}, isr unchanged.
- rst_n asserted during WAIT2 -> data_oe = 0, isr = 0, and state = IDLE immediately. After release, a fresh request completes normally.
- With PIC_AUTO_EOI_EN and aeoi = 1, irr = 8'h01 -> isr = 8'h01 after the first pulse and 8'h00 after the second rising edge.
